// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: one access in flight, word-addressed memory bus with
// byte strobes, sign/zero-extended load data returned on the register-file write port.
module ysyx_24100005_lsu #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_wen,
    output logic [RD_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, ERR} state_t;

    state_t          state;
    logic            store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [RD_W-1:0] rd_q;

    function automatic logic is_bad(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = st ? (f3 > 3'b010) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return illegal || misaligned;
    endfunction

    function automatic logic [3:0] lane_strb(input logic st, input logic [1:0] sz, input logic [1:0] a);
        if (!st) return 4'b0000;
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_data(input logic [1:0] sz, input logic [XLEN-1:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [XLEN-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return rd;
        endcase
    endfunction

    // Bus fields come straight from the captured request, so they cannot move while REQ stalls.
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wen   = store_q;
    assign mem_wdata = lane_data(funct3_q[1:0], wdata_q);
    assign mem_wstrb = lane_strb(store_q, funct3_q[1:0], addr_q[1:0]);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values; mixing in blocking writes would create ordering bugs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            rf_wen        <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            store_q       <= 1'b0;
            funct3_q      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rf_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        store_q   <= req_store;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rd_q      <= req_rd;
                        req_ready <= 1'b0;
                        if (is_bad(req_store, req_funct3, req_addr[1:0])) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state <= WB;
                        done  <= 1'b1;
                        if (!store_q && rd_q != '0) begin
                            rf_wen   <= 1'b1;
                            rf_waddr <= rd_q;
                            rf_wdata <= load_ext(funct3_q, addr_q[1:0], mem_rdata);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
